// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM encodings,
// the NOP returned on a timed-out fetch and the default ack timeout.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StDWait = 3'd1,
    StIWait = 3'd2,
    StIDrop = 3'd3,
    StResp  = 3'd4
  } arb_state_e;

  localparam logic [31:0]  NopInstr   = 32'h0000_0013;
  localparam int unsigned  DefTimeout = 16;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating wait-cycle counter; expired flags the last permitted waiting cycle.
// A TIMEOUT of 0 disables expiry entirely.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] LastCnt = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != LastCnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (TIMEOUT > 0) && (r_cnt >= LastCnt);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch and data ports.
// Data wins collisions; a flushed fetch is run to completion and its data discarded.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned        ADDR_W  = 32,
  parameter int unsigned        DATA_W  = 32,
  parameter int unsigned        TIMEOUT = DefTimeout,
  parameter logic [DATA_W-1:0]  NOP     = DATA_W'(NopInstr)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              flush,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              err
);

  arb_state_e        r_state, w_state_nxt;
  logic              r_m_req, w_m_req_nxt;
  logic              r_m_we, w_m_we_nxt;
  logic [ADDR_W-1:0] r_m_addr, w_m_addr_nxt;
  logic [DATA_W-1:0] r_m_wdata, w_m_wdata_nxt;
  logic [DATA_W-1:0] r_i_rdata, w_i_rdata_nxt;
  logic [DATA_W-1:0] r_d_rdata, w_d_rdata_nxt;
  logic              r_i_valid, w_i_valid_nxt;
  logic              r_d_valid, w_d_valid_nxt;
  logic              r_err, w_err_nxt;
  logic              w_ctr_clr, w_ctr_en, w_expired;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_ctr_clr),
    .en      (w_ctr_en),
    .expired (w_expired)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_m_req_nxt   = r_m_req;
    w_m_we_nxt    = r_m_we;
    w_m_addr_nxt  = r_m_addr;
    w_m_wdata_nxt = r_m_wdata;
    w_i_rdata_nxt = r_i_rdata;
    w_d_rdata_nxt = r_d_rdata;
    w_i_valid_nxt = 1'b0;
    w_d_valid_nxt = 1'b0;
    w_err_nxt     = 1'b0;
    w_ctr_clr     = 1'b0;
    w_ctr_en      = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_ctr_clr = 1'b1;
        if (d_req) begin
          w_m_req_nxt   = 1'b1;
          w_m_we_nxt    = d_we;
          w_m_addr_nxt  = d_addr;
          w_m_wdata_nxt = d_wdata;
          w_state_nxt   = StDWait;
        end else if (i_req) begin
          w_m_req_nxt  = 1'b1;
          w_m_we_nxt   = 1'b0;
          w_m_addr_nxt = i_addr;
          w_state_nxt  = StIWait;
        end
      end
      StDWait: begin
        if (m_ack) begin
          w_m_req_nxt   = 1'b0;
          w_d_valid_nxt = 1'b1;
          w_state_nxt   = StResp;
          if (!r_m_we) w_d_rdata_nxt = m_rdata;
        end else if (w_expired) begin
          w_m_req_nxt   = 1'b0;
          w_d_rdata_nxt = '0;
          w_d_valid_nxt = 1'b1;
          w_err_nxt     = 1'b1;
          w_state_nxt   = StResp;
        end else begin
          w_ctr_en = 1'b1;
        end
      end
      StIWait: begin
        // ack beats timeout; a flush only decides whether the result is delivered
        if (m_ack) begin
          w_m_req_nxt = 1'b0;
          if (flush) begin
            w_state_nxt = StIdle;
          end else begin
            w_i_rdata_nxt = m_rdata;
            w_i_valid_nxt = 1'b1;
            w_state_nxt   = StResp;
          end
        end else if (w_expired) begin
          w_m_req_nxt = 1'b0;
          w_err_nxt   = 1'b1;
          if (flush) begin
            w_state_nxt = StIdle;
          end else begin
            w_i_rdata_nxt = NOP;
            w_i_valid_nxt = 1'b1;
            w_state_nxt   = StResp;
          end
        end else begin
          w_ctr_en = 1'b1;
          if (flush) w_state_nxt = StIDrop;
        end
      end
      StIDrop: begin
        if (m_ack) begin
          w_m_req_nxt = 1'b0;
          w_state_nxt = StIdle;
        end else if (w_expired) begin
          w_m_req_nxt = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = StIdle;
        end else begin
          w_ctr_en = 1'b1;
        end
      end
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_m_req   <= w_m_req_nxt;
      r_m_we    <= w_m_we_nxt;
      r_m_addr  <= w_m_addr_nxt;
      r_m_wdata <= w_m_wdata_nxt;
      r_i_rdata <= w_i_rdata_nxt;
      r_d_rdata <= w_d_rdata_nxt;
      r_i_valid <= w_i_valid_nxt;
      r_d_valid <= w_d_valid_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign m_req   = r_m_req;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign i_valid = r_i_valid;
  assign d_valid = r_d_valid;
  assign err     = r_err;
  assign i_stall = i_req && !r_i_valid;
  assign d_stall = d_req && !r_d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: load, collision, flush, timeout and reset cases.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, flush, d_req, d_we, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_valid, i_stall, d_valid, d_stall, m_req, m_we, err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4),
    .NOP     (32'h0000_0013)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .flush   (flush),
    .i_rdata (i_rdata),
    .i_valid (i_valid),
    .i_stall (i_stall),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_valid (d_valid),
    .d_stall (d_stall),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack),
    .err     (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; i_req = 1'b0; flush = 1'b0; d_req = 1'b0; d_we = 1'b0; m_ack = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    tick(); tick();
    check_eq("rst_m_req", 32'(m_req), 0);
    check_eq("rst_valids", {30'd0, i_valid, d_valid}, 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_rdata", i_rdata | d_rdata, 0);
    reset = 1'b1;
    tick();

    // Load, zero wait states
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    tick();
    check_eq("ld_m_req", 32'(m_req), 1);
    check_eq("ld_m_addr", m_addr, 32'h40);
    check_eq("ld_m_we", 32'(m_we), 0);
    check_eq("ld_d_stall", 32'(d_stall), 1);
    m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
    tick();
    check_eq("ld_d_valid", 32'(d_valid), 1);
    check_eq("ld_d_rdata", d_rdata, 32'hDEAD_BEEF);
    check_eq("ld_m_req_clr", 32'(m_req), 0);
    check_eq("ld_d_stall_clr", 32'(d_stall), 0);
    d_req = 1'b0; m_ack = 1'b0;
    tick();
    check_eq("ld_d_valid_pulse", 32'(d_valid), 0);

    // Collision: store wins, fetch follows after RESP
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h55;
    tick();
    check_eq("col_m_addr", m_addr, 32'h80);
    check_eq("col_m_we", 32'(m_we), 1);
    check_eq("col_m_wdata", m_wdata, 32'h55);
    check_eq("col_i_stall", 32'(i_stall), 1);
    m_ack = 1'b1; m_rdata = 32'h1111_1111;
    tick();
    check_eq("col_d_valid", 32'(d_valid), 1);
    check_eq("col_store_rdata", d_rdata, 32'hDEAD_BEEF);
    check_eq("col_i_stall2", 32'(i_stall), 1);
    d_req = 1'b0; m_ack = 1'b0;
    tick();
    check_eq("col_resp_no_req", 32'(m_req), 0);
    tick();
    check_eq("col_f_m_req", 32'(m_req), 1);
    check_eq("col_f_m_addr", m_addr, 32'h200);
    check_eq("col_f_m_we", 32'(m_we), 0);
    m_ack = 1'b1; m_rdata = 32'h1234_5678;
    tick();
    check_eq("col_i_valid", 32'(i_valid), 1);
    check_eq("col_i_rdata", i_rdata, 32'h1234_5678);
    check_eq("col_i_stall_clr", 32'(i_stall), 0);
    i_req = 1'b0; m_ack = 1'b0;
    tick();
    check_eq("col_i_valid_pulse", 32'(i_valid), 0);

    // Flush during a 4-cycle ack delay
    i_req = 1'b1; i_addr = 32'h100;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; i_addr = 32'h300;
    check_eq("fl_m_req_held", 32'(m_req), 1);
    check_eq("fl_m_addr_held", m_addr, 32'h100);
    tick(); tick();
    m_ack = 1'b1; m_rdata = 32'hBAD0_BAD0;
    check_eq("fl_no_valid_wait", 32'(i_valid), 0);
    tick();
    check_eq("fl_m_req_clr", 32'(m_req), 0);
    check_eq("fl_no_valid", 32'(i_valid), 0);
    check_eq("fl_no_err", 32'(err), 0);
    m_ack = 1'b0;
    tick();
    check_eq("fl_next_m_req", 32'(m_req), 1);
    check_eq("fl_next_m_addr", m_addr, 32'h300);

    // Flush coincident with ack
    flush = 1'b1; m_ack = 1'b1; m_rdata = 32'hBAD1_BAD1;
    tick();
    check_eq("fa_no_valid", 32'(i_valid), 0);
    check_eq("fa_m_req_clr", 32'(m_req), 0);
    flush = 1'b0; m_ack = 1'b0; i_addr = 32'h400;
    tick();
    check_eq("fa_idle_issue", 32'(m_req), 1);
    check_eq("fa_idle_addr", m_addr, 32'h400);
    m_ack = 1'b1; m_rdata = 32'hCAFE_F00D;
    tick();
    check_eq("fa_i_valid", 32'(i_valid), 1);
    check_eq("fa_i_rdata", i_rdata, 32'hCAFE_F00D);
    i_req = 1'b0; m_ack = 1'b0;
    tick();

    // Load timeout
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("to_ld_m_req%0d", i), {30'd0, m_req, err}, 32'h2);
    end
    tick();
    check_eq("to_ld_m_req_clr", 32'(m_req), 0);
    check_eq("to_ld_err", 32'(err), 1);
    check_eq("to_ld_d_valid", 32'(d_valid), 1);
    check_eq("to_ld_d_rdata", d_rdata, 0);
    d_req = 1'b0;
    tick();
    check_eq("to_ld_err_pulse", {30'd0, err, d_valid}, 0);

    // Fetch timeout
    i_req = 1'b1; i_addr = 32'h500;
    tick();
    for (int i = 0; i < 3; i++) tick();
    check_eq("to_f_m_req_last", 32'(m_req), 1);
    tick();
    check_eq("to_f_err", 32'(err), 1);
    check_eq("to_f_i_valid", 32'(i_valid), 1);
    check_eq("to_f_i_rdata", i_rdata, 32'h0000_0013);
    i_req = 1'b0;
    tick();

    // Reset mid-transaction, late ack ignored
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h90; d_wdata = 32'h77;
    tick();
    check_eq("rs_m_req", 32'(m_req), 1);
    reset = 1'b0; d_req = 1'b0;
    tick();
    check_eq("rs_m_req_clr", 32'(m_req), 0);
    check_eq("rs_outs", {29'd0, d_valid, i_valid, err}, 0);
    check_eq("rs_i_rdata", i_rdata, 0);
    reset = 1'b1; m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
    tick();
    check_eq("rs_late_ack", {30'd0, m_req, d_valid}, 0);
    check_eq("rs_late_rdata", d_rdata, 0);
    m_ack = 1'b0; i_req = 1'b1; i_addr = 32'h600;
    tick();
    check_eq("rs_idle_issue", m_addr, 32'h600);
    m_ack = 1'b1; m_rdata = 32'h0;
    tick();
    i_req = 1'b0; m_ack = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
